// File: rtl/temp_avg_filter_pkg.sv
// Shared state encoding, widths and sign-magnitude helpers for the
// temperature moving-average filter.
package temp_filter_pkg;

    localparam int DEFAULT_DIN_W = 21;
    // Helpers work at a fixed generous width; callers size-cast in and out.
    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        FULL
    } state_t;

    function automatic logic signed [MAX_W-1:0] sm_to_tc(input logic [MAX_W-1:0] mag,
                                                          input logic sign);
        return sign ? -$signed(mag) : $signed(mag);
    endfunction

    function automatic logic [MAX_W-1:0] tc_mag(input logic signed [MAX_W-1:0] v);
        return v[MAX_W-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    // Only strictly negative values report a sign, so zero is never negative.
    function automatic logic tc_sign(input logic signed [MAX_W-1:0] v);
        return v[MAX_W-1];
    endfunction

    function automatic int round_const(input int log2);
        return 1 << (log2 - 1);
    endfunction

endpackage

// File: rtl/temp_avg_filter_ring.sv
// Window history for the moving-average filter: one write port, an
// asynchronous read at the same pointer, and a synchronous clear.
module temp_avg_ring #(
    parameter int W          = 22,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] ptr,
    input  logic [W-1:0]          wdata,
    output logic [W-1:0]          rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[ptr] <= wdata;
        end
    end

    assign rdata = mem[ptr];

endmodule

// File: rtl/temp_avg_filter.sv
// Sliding-window moving average over sign-magnitude temperature samples.
// Define TEMP_AVG_SPIKE_REJECT_EN to add outlier rejection and spike_rej.
module temp_avg_filter
    import temp_filter_pkg::*;
#(
    parameter int DIN_W    = DEFAULT_DIN_W,
    parameter int AVG_LOG2 = 3,
    parameter int SPIKE_TH = 20000,
    parameter int MAX_REJ  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIN_W-1:0] din,
    input  logic             din_sign,
    input  logic             din_vld,
    input  logic             clr,
    output logic [DIN_W-1:0] dout,
    output logic             dout_sign,
    output logic             dout_vld
`ifdef TEMP_AVG_SPIKE_REJECT_EN
    ,
    output logic             spike_rej
`endif
);

    localparam int W1    = DIN_W + 1;
    localparam int ACC_W = W1 + AVG_LOG2;
    localparam int N     = 1 << AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;

    if (AVG_LOG2 < 1 || AVG_LOG2 > 5 || W1 > MAX_W || MAX_REJ < 1 || SPIKE_TH < 0) begin : g_bad_params
        $error("temp_avg_filter: illegal parameter set");
    end

    state_t                    state, state_next;
    logic [AVG_LOG2-1:0]       wr_ptr;
    logic [CNT_W-1:0]          count;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   rounded;
    logic signed [W1-1:0]      avg_now;
    logic signed [W1-1:0]      oldest;

    logic                      s1_vld;
    logic signed [W1-1:0]      s1_neg;
    logic                      s2_vld, s2_pass, s2_rej;
    logic signed [W1-1:0]      s2_val;
    logic                      s3_vld, s3_rej;
    logic signed [W1-1:0]      s3_val;

    logic                      pass_thru, reject, wr_en;

    assign rounded = sum + ACC_W'(round_const(AVG_LOG2));
    assign avg_now = W1'(rounded >>> AVG_LOG2);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            s1_vld <= 1'b0;
            s1_neg <= '0;
        end else begin
            s1_vld <= din_vld;
            if (din_vld) begin
                s1_neg <= W1'(sm_to_tc(MAX_W'(din), din_sign));
            end
        end
    end

    // The oldest entry is read in the same cycle it is overwritten, which
    // keeps back-to-back samples free of pointer hazards.
    temp_avg_ring #(
        .W          (W1),
        .DEPTH_LOG2 (AVG_LOG2)
    ) u_ring (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .we    (wr_en),
        .ptr   (wr_ptr),
        .wdata (s1_neg),
        .rdata (oldest)
    );

`ifdef TEMP_AVG_SPIKE_REJECT_EN
    localparam int W2    = W1 + 1;
    localparam int REJ_W = $clog2(MAX_REJ + 1);

    logic [REJ_W-1:0]     rej_cnt;
    logic signed [W2-1:0] diff;
    logic                 out_of_band;

    assign diff        = W2'(s1_neg) - W2'(avg_now);
    assign out_of_band = (diff > W2'(SPIKE_TH)) || (diff < -W2'(SPIKE_TH));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            rej_cnt <= '0;
        end else if (s1_vld) begin
            rej_cnt <= reject ? rej_cnt + REJ_W'(1) : '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (wr_en && state != FULL) begin
            state_next = (count == CNT_W'(N - 1)) ? FULL : FILL;
        end
    end

    always_comb begin
        pass_thru = (state != FULL) && (count < CNT_W'(N - 1));
        reject    = 1'b0;
`ifdef TEMP_AVG_SPIKE_REJECT_EN
        reject    = (state == FULL) && out_of_band && (rej_cnt < REJ_W'(MAX_REJ));
`endif
        wr_en     = s1_vld && !clr && !reject;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            sum     <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            s2_vld  <= 1'b0;
            s2_pass <= 1'b0;
            s2_rej  <= 1'b0;
            s2_val  <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_val  <= s1_neg;
                s2_pass <= pass_thru;
                s2_rej  <= reject;
            end
            if (wr_en) begin
                sum    <= sum + ACC_W'(s1_neg) - ACC_W'(oldest);
                wr_ptr <= wr_ptr + AVG_LOG2'(1);
                if (count != CNT_W'(N)) begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            s3_vld <= 1'b0;
            s3_rej <= 1'b0;
            s3_val <= '0;
        end else begin
            s3_vld <= s2_vld;
            if (s2_vld) begin
                s3_rej <= s2_rej;
                s3_val <= s2_pass ? s2_val : avg_now;
            end
        end
    end

    // A rejected sample still strobes, but the previous reading is held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout      <= '0;
            dout_sign <= 1'b0;
            dout_vld  <= 1'b0;
`ifdef TEMP_AVG_SPIKE_REJECT_EN
            spike_rej <= 1'b0;
`endif
        end else if (clr) begin
            dout_vld  <= 1'b0;
`ifdef TEMP_AVG_SPIKE_REJECT_EN
            spike_rej <= 1'b0;
`endif
        end else begin
            dout_vld <= s3_vld;
            if (s3_vld && !s3_rej) begin
                dout      <= DIN_W'(tc_mag(MAX_W'(s3_val)));
                dout_sign <= tc_sign(MAX_W'(s3_val));
            end
`ifdef TEMP_AVG_SPIKE_REJECT_EN
            spike_rej <= s3_vld && s3_rej;
`endif
        end
    end

endmodule

// File: tb/tb_temp_avg_filter.sv
// Directed bench for temp_avg_filter: hand-computed expected readings are
// queued per sample and matched against each dout_vld strobe.
module tb_temp_avg_filter;

    localparam int DIN_W = 21;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DIN_W-1:0] din;
    logic             din_sign;
    logic             din_vld;
    logic             clr;
    logic [DIN_W-1:0] dout;
    logic             dout_sign;
    logic             dout_vld;
`ifdef TEMP_AVG_SPIKE_REJECT_EN
    logic             spike_rej;
`endif

    typedef struct {
        int unsigned mag;
        logic        sign;
        logic        rej;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc_cnt    = 0;
    int          assert_cnt = 0;
    int          fail_cnt   = 0;

    temp_avg_filter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_sign  (din_sign),
        .din_vld   (din_vld),
        .clr       (clr),
        .dout      (dout),
        .dout_sign (dout_sign),
        .dout_vld  (dout_vld)
`ifdef TEMP_AVG_SPIKE_REJECT_EN
        ,
        .spike_rej (spike_rej)
`endif
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic checkOutput(input string tag, input longint got, input longint expv);
        assert_cnt++;
        if (got !== expv) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, expv);
        end
    endtask

    // Drives one sample for one cycle, starting and ending on a falling edge.
    task automatic applyStimulus(input int unsigned mag, input logic sign, input bit expect_out,
                                 input int unsigned exp_mag, input logic exp_sign,
                                 input logic exp_rej);
        exp_t e;
        din      = DIN_W'(mag);
        din_sign = sign;
        din_vld  = 1'b1;
        if (expect_out) begin
            e.mag  = exp_mag;
            e.sign = exp_sign;
            e.rej  = exp_rej;
            e.cyc  = cyc_cnt + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        din_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseClr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (dout_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_vld", 1, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("latency", longint'(cyc_cnt - e.cyc), 3);
                checkOutput("dout", dout, e.mag);
                checkOutput("dout_sign", dout_sign, e.sign);
`ifdef TEMP_AVG_SPIKE_REJECT_EN
                checkOutput("spike_rej", spike_rej, e.rej);
`endif
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        din      = '0;
        din_sign = 1'b0;
        din_vld  = 1'b0;
        clr      = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_dout", dout, 0);
        checkOutput("rst_dout_sign", dout_sign, 0);
        checkOutput("rst_dout_vld", dout_vld, 0);
`ifdef TEMP_AVG_SPIKE_REJECT_EN
        checkOutput("rst_spike_rej", spike_rej, 0);
`endif
        rst_n = 1'b1;
        idle(2);

        $display("[TB] fill with +250625");
        for (int i = 0; i < 8; i++) applyStimulus(250625, 1'b0, 1'b1, 250625, 1'b0, 1'b0);
        idle(6);
        checkOutput("drain_fill", exp_q.size(), 0);

        $display("[TB] step 200000 -> 280000");
        pulseClr();
        for (int i = 0; i < 8; i++) applyStimulus(200000, 1'b0, 1'b1, 200000, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++)
            applyStimulus(280000, 1'b0, 1'b1, 200000 + 10000 * k, 1'b0, 1'b0);
        idle(6);
        checkOutput("drain_step", exp_q.size(), 0);

        $display("[TB] rounding and sign");
        pulseClr();
        for (int i = 0; i < 7; i++) applyStimulus(0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        applyStimulus(4, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        idle(6);
        pulseClr();
        for (int i = 0; i < 7; i++) applyStimulus(0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        applyStimulus(4, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        idle(6);
        pulseClr();
        for (int i = 0; i < 8; i++) applyStimulus(5000, 1'b0, 1'b1, 5000, 1'b0, 1'b0);
        applyStimulus(5000, 1'b1, 1'b1, 3750, 1'b0, 1'b0);
        applyStimulus(5000, 1'b1, 1'b1, 2500, 1'b0, 1'b0);
        applyStimulus(5000, 1'b1, 1'b1, 1250, 1'b0, 1'b0);
        applyStimulus(5000, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        applyStimulus(5000, 1'b1, 1'b1, 1250, 1'b1, 1'b0);
        idle(6);
        checkOutput("drain_round", exp_q.size(), 0);

        $display("[TB] clr with din_vld mid-fill");
        pulseClr();
        applyStimulus(100, 1'b0, 1'b1, 100, 1'b0, 1'b0);
        applyStimulus(200, 1'b0, 1'b1, 200, 1'b0, 1'b0);
        applyStimulus(300, 1'b0, 1'b1, 300, 1'b0, 1'b0);
        idle(6);
        clr = 1'b1;
        applyStimulus(777, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        clr = 1'b0;
        applyStimulus(123456, 1'b0, 1'b1, 123456, 1'b0, 1'b0);
        idle(6);
        checkOutput("drain_clr", exp_q.size(), 0);
        checkOutput("clr_hold_dout", dout, 123456);

        $display("[TB] reset mid-pipeline");
        applyStimulus(55555, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        checkOutput("midrst_dout", dout, 0);
        checkOutput("midrst_dout_sign", dout_sign, 0);
        checkOutput("midrst_dout_vld", dout_vld, 0);

`ifdef TEMP_AVG_SPIKE_REJECT_EN
        $display("[TB] spike rejection");
        for (int i = 0; i < 8; i++) applyStimulus(250000, 1'b0, 1'b1, 250000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(300000, 1'b0, 1'b1, 250000, 1'b0, 1'b1);
        applyStimulus(300000, 1'b0, 1'b1, 256250, 1'b0, 1'b0);
        idle(6);
        checkOutput("drain_spike", exp_q.size(), 0);
`endif

        checkOutput("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/temp_avg_filter.md
Name: temp_avg_filter

Overview:
- Sliding-window moving-average filter between the DS18B20 driver and the binary-to-BCD converter.
- Consumes each sign-magnitude temperature sample (magnitude scaled ×10000, i.e. 0.0625 °C = 625) with its valid pulse.
- Emits a smoothed sign-magnitude sample with a valid pulse, so the BCD, segment and LCD stages show a stable reading.

Parameters:
- DIN_W, 21, magnitude width of din/dout
- AVG_LOG2, 3, log2 of window length N (N = 8 by default); legal range 1..5
- SPIKE_TH, 20000, max |sample − current average| accepted; used only with the optional feature
- MAX_REJ, 3, consecutive rejections before a sample is force-accepted; used only with the optional feature

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  synchronous active-low reset
- din  in  DIN_W  input magnitude
- din_sign  in  1  input sign, 1 = negative
- din_vld  in  1  one-cycle sample strobe
- clr  in  1  synchronous flush of window history
- dout  out  DIN_W  filtered magnitude
- dout_sign  out  1  filtered sign
- dout_vld  out  1  one-cycle result strobe
- spike_rej  out  1  one-cycle pulse when a sample is rejected; present only with the optional feature

Behaviour:
- One clock domain. Reset is synchronous and active-low: rst_n sampled low on a clk edge resets the block.
- Reset values: dout = 0, dout_sign = 0, dout_vld = 0, spike_rej = 0. Internally: sum = 0, write pointer = 0, count = 0, state = EMPTY, all ring-buffer entries = 0.
- Internal arithmetic is two's complement, width DIN_W+1.
  - Accumulator width: DIN_W+1+AVG_LOG2.
  - Conversion: neg = din_sign ? −din : din.
- Pipeline stage 1 (accept edge, din_vld = 1): register neg; read the oldest entry at the write pointer.
- Pipeline stage 2:
  - sum ← sum + neg − oldest.
  - Write neg at the pointer; pointer ← pointer + 1, wrapping modulo N.
  - count saturates at N.
- Pipeline stage 3 (output):
  - avg = (sum + N/2) >>> AVG_LOG2: arithmetic shift, round half toward +inf.
  - Convert avg to sign-magnitude. A zero result forces dout_sign = 0 (no negative zero).
- Latency: dout_vld is high for exactly one cycle, 3 clocks after the accepting edge.
- din_vld may be asserted every cycle at full throughput. dout/dout_sign hold their value between strobes.
- States:
  - EMPTY → FILL on the first accepted sample.
  - FILL → FULL when the Nth sample is written.
  - FULL stays in FULL.
  - Any state → EMPTY on clr.
- In EMPTY/FILL, samples 1..N−1 are passed through unchanged but still written to the buffer. The Nth sample onward outputs the window average.
- Arithmetic is exact during fill because unused entries hold 0.
- clr:
  - Same effect as reset on sum, pointer, count, state and buffer.
  - Discards any in-flight samples, so no dout_vld results from them.
  - dout/dout_sign hold their last values.
  - If clr and din_vld are high together, clr wins and the sample is dropped.
- rst_n low mid-pipeline: all in-flight samples are discarded and outputs return to reset values.
- Input magnitudes above the representable range are not checked. The sensor range (−55..+125 °C) fits within DIN_W = 21.

Optional Feature:
- Macro: TEMP_AVG_SPIKE_REJECT_EN.
- With the macro, in FULL only:
  - A sample with |neg − current avg| > SPIKE_TH is not written to the buffer.
  - dout_vld still pulses with the previous dout unchanged, and spike_rej pulses in the same cycle.
  - After MAX_REJ consecutive rejections, the next out-of-band sample is accepted normally.
  - Any accepted sample resets the rejection counter.
- Without the macro: no spike_rej port and no comparison logic; every sample is accepted.

Decomposition:
- Package temp_filter_pkg holds:
  - the default DIN_W
  - the state encoding EMPTY/FILL/FULL
  - sign-magnitude ↔ two's-complement conversion functions
  - the rounding constant expression
- Natural sub-module: temp_avg_ring, an N × (DIN_W+1) ring buffer with a single write port, an asynchronous read at the pointer, and synchronous clear.

Test Plan:
- Reset, then 8 samples of +250625 → outputs 1–7 equal 250625 (pass-through); output 8 equals 250625, sign 0; each dout_vld exactly 3 clocks after its din_vld.
- Window full of 200000, then 8 samples of 280000 → the k-th new output is 200000+10000·k, ending at 280000.
- Rounding and sign:
  - Window holds 7×0 plus one +4 → dout = 1, sign 0.
  - Window holds 7×0 plus one −4 → dout = 0, sign 0 (half up; no negative zero).
  - 8×(+5000) followed by 4×(−5000) → 4th output 0, sign 0; a 5th −5000 → dout = 1250, sign 1.
- clr asserted together with din_vld mid-FILL (3 samples in) → no dout_vld for that sample; the next sample 123456 passes through as 123456.
- rst_n low for 1 cycle one clock after a din_vld → that sample's dout_vld never appears; dout = 0, sign 0.
- With TEMP_AVG_SPIKE_REJECT_EN, window full of 250000:
  - Inputs 300000 ×3 → dout stays 250000, spike_rej pulses 3 times.
  - 4th 300000 is accepted → dout = 256250.
